// File: rtl/traditional_smart_array_ctrl.sv
// traditional_smart_array_ctrl: tile sequencer for the SMART systolic array.
// Optional abort input is enabled by defining TRADITIONAL_SMART_CTRL_ABORT_EN.
module traditional_smart_array_ctrl #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KW   = 16,
    parameter int SW   = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TRADITIONAL_SMART_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic [SW-1:0]        hor_stride,
    input  logic [SW-1:0]        ver_stride,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] hor_ssr_bus_out,
    output logic [COLS*ROWS-1:0] ver_ssr_bus_out,
    output logic                 ctl_stat_bit,
    output logic                 ctl_fsm_op2_select,
    output logic                 ctl_fsm_out_select,
    output logic                 feed_en,
    output logic [KW-1:0]        feed_idx
);

    localparam int D  = (ROWS > COLS) ? ROWS : COLS;
    localparam int CW = KW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_LOAD,
        S_COMP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_stat;
    logic            r_op2;
    logic            r_out;
    logic            r_feed_en;
    logic [KW-1:0]   r_feed_idx;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_k;
    logic [SW-1:0]   r_hs;
    logic [SW-1:0]   r_vs;
    logic [SW-1:0]   r_hmod;
    logic [SW-1:0]   r_vmod;
    logic [COLS-1:0] r_hmask;
    logic [ROWS-1:0] r_vmask;

    logic            w_abort;
    logic [SW-1:0]   w_hs_norm;
    logic [SW-1:0]   w_vs_norm;
    logic [CW-1:0]   w_comp_end;
    logic            w_cfg_last;
    logic            w_load_last;
    logic            w_comp_last;
    logic            w_drain_last;
    logic            w_feed_last;

`ifdef TRADITIONAL_SMART_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // stride 0 behaves as 1, oversize strides saturate at the dimension
    assign w_hs_norm = (hor_stride == '0) ? SW'(1) :
                       (hor_stride > SW'(COLS)) ? SW'(COLS) : hor_stride;
    assign w_vs_norm = (ver_stride == '0) ? SW'(1) :
                       (ver_stride > SW'(ROWS)) ? SW'(ROWS) : ver_stride;

    // compute phase spans k+ROWS+COLS-2 cycles; one extra bit avoids wrap
    assign w_comp_end   = {1'b0, r_k} + CW'(ROWS + COLS - 3);
    assign w_cfg_last   = (r_cnt == CW'(D - 1));
    assign w_load_last  = (r_cnt == CW'(ROWS - 1));
    assign w_comp_last  = (r_cnt == w_comp_end);
    assign w_drain_last = (r_cnt == CW'(ROWS - 1));
    assign w_feed_last  = (r_feed_idx == r_k - KW'(1));

    // sequencer: state, phase counter, masks and all registered controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stat     <= 1'b0;
            r_op2      <= 1'b0;
            r_out      <= 1'b0;
            r_feed_en  <= 1'b0;
            r_feed_idx <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_hs       <= SW'(1);
            r_vs       <= SW'(1);
            r_hmod     <= '0;
            r_vmod     <= '0;
            r_hmask    <= '0;
            r_vmask    <= '0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stat     <= 1'b0;
            r_op2      <= 1'b0;
            r_out      <= 1'b0;
            r_feed_en  <= 1'b0;
            r_feed_idx <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k    <= k_len;
                        r_hs   <= w_hs_norm;
                        r_vs   <= w_vs_norm;
                        r_cnt  <= '0;
                        r_hmod <= '0;
                        r_vmod <= '0;
                        r_busy <= 1'b1;
                        if (k_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    for (int c = 0; c < COLS; c++) begin
                        if (r_cnt == CW'(c)) r_hmask[c] <= (r_hmod != '0);
                    end
                    for (int r = 0; r < ROWS; r++) begin
                        if (r_cnt == CW'(r)) r_vmask[r] <= (r_vmod != '0);
                    end
                    r_hmod <= (r_hmod == r_hs - SW'(1)) ? '0 : r_hmod + SW'(1);
                    r_vmod <= (r_vmod == r_vs - SW'(1)) ? '0 : r_vmod + SW'(1);
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_cfg_last) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_stat  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_load_last) begin
                        r_state    <= S_COMP;
                        r_cnt      <= '0;
                        r_stat     <= 1'b0;
                        r_op2      <= 1'b1;
                        r_feed_en  <= 1'b1;
                        r_feed_idx <= '0;
                    end
                end
                S_COMP: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_feed_en) begin
                        if (w_feed_last) begin
                            r_feed_en  <= 1'b0;
                            r_feed_idx <= '0;
                        end else begin
                            r_feed_idx <= r_feed_idx + KW'(1);
                        end
                    end
                    if (w_comp_last) begin
                        r_state    <= S_DRAIN;
                        r_cnt      <= '0;
                        r_op2      <= 1'b0;
                        r_out      <= 1'b1;
                        r_feed_en  <= 1'b0;
                        r_feed_idx <= '0;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_drain_last) begin
                        r_state <= S_DONE;
                        r_out   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // broadcast the per-column / per-row masks across the whole array
    always_comb begin
        hor_ssr_bus_out = '0;
        ver_ssr_bus_out = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                hor_ssr_bus_out[r*COLS+c] = r_hmask[c];
                ver_ssr_bus_out[c*ROWS+r] = r_vmask[r];
            end
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign ctl_stat_bit       = r_stat;
    assign ctl_fsm_op2_select = r_op2;
    assign ctl_fsm_out_select = r_out;
    assign feed_en            = r_feed_en;
    assign feed_idx           = r_feed_idx;

endmodule

// File: doc/traditional_smart_array_ctrl.md
# traditional_smart_array_ctrl

Sequencer for the traditional SMART systolic array. It drives the horizontal and vertical SSR bypass buses, the stationary-load / op2 / out control bits, and the operand-feed strobe. One start request runs one tile through five phases: configure, weight load, compute, drain, done. It sits between the tile scheduler (start/done handshake) and the array instance plus its operand buffers.

## Interface
Parameters:
- ROWS, 8, array rows
- COLS, 8, array columns
- KW, 16, width of the reduction-length field
- SW = $clog2(MAX(ROWS,COLS)+1), width of the stride fields

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  run request; sampled only in IDLE
- k_len  in  KW  reduction length of the tile; latched on accepted start
- hor_stride  in  SW  horizontal hop stride; latched on start
- ver_stride  in  SW  vertical hop stride; latched on start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- hor_ssr_bus_out  out  ROWS*COLS  feeds array hor_ssr_bus_in; bit r*COLS+c
- ver_ssr_bus_out  out  COLS*ROWS  feeds array ver_ssr_bus_in; bit c*ROWS+r
- ctl_stat_bit  out  1  stationary-operand load enable
- ctl_fsm_op2_select  out  1  accumulate select
- ctl_fsm_out_select  out  1  output/drain select
- feed_en  out  1  operand-buffer read strobe
- feed_idx  out  KW  operand index for feed_en

## Operation
- FSM states and transitions:
  - IDLE: start=1 and k_len!=0 → CFG. start=1 and k_len==0 → DONE.
  - CFG: lasts D = max(ROWS,COLS) cycles, then → LOAD.
  - LOAD: lasts ROWS cycles; ctl_stat_bit=1. Then → COMPUTE.
  - COMPUTE: lasts k_len+ROWS+COLS-2 cycles; ctl_fsm_op2_select=1. Then → DRAIN.
  - DRAIN: lasts ROWS cycles; ctl_fsm_out_select=1. Then → DONE.
  - DONE: 1 cycle; done=1. Then → IDLE.
- Stride normalisation at latch:
  - stride 0 is treated as 1.
  - stride > dimension is clamped to the dimension.
- SSR mask rule (1 = bypass the MAC):
  - Horizontal bit for column c is 1 iff (c mod hs) != 0. The mask is identical for every row.
  - Vertical bit for row r is 1 iff (r mod vs) != 0. The mask is identical for every column.
- Mask generation:
  - In CFG, a phase counter i = 0..D-1 and two modulo counters (no dividers) write column i and row i of the masks, when in range.
  - The SSR buses are registered. They change only during CFG and hold stable through LOAD, COMPUTE, DRAIN and IDLE until the next CFG.
- Operand feed:
  - feed_en=1 for the first k_len cycles of COMPUTE.
  - feed_idx counts 0..k_len-1 and returns to 0 when feed_en drops.
- start asserted while busy is ignored and not queued.

## Timing
- Reset values: all outputs 0; state IDLE; both SSR buses all-zero (no bypass).
- Start accepted at edge t → CFG occupies cycles t+1..t+D.
- For start at t, done is high in cycle t + D + ROWS + (k_len+ROWS+COLS-2) + ROWS + 1.
- For k_len==0, done is high in cycle t+1 and the SSR buses are unchanged.
- busy rises the cycle after acceptance and falls the cycle after done.
- The control bits are mutually exclusive. Each is registered and aligned with its state, with no combinational path from inputs.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, SSR buses cleared, and no done pulse.
- k_len = 2^KW-1: the COMPUTE counter is KW+1 bits wide and must not wrap.

## Configuration
- TRADITIONAL_SMART_CTRL_ABORT_EN
  - Defined: adds input abort (1 bit). abort=1 in any non-IDLE state → IDLE on the next edge. All control bits and feed_en drop, no done pulse, and the SSR buses retain their value.
  - Undefined: the port does not exist and every run completes.

## Test plan
- ROWS=COLS=4, k_len=8, strides 1/1, start at cycle 0 → CFG 1-4, LOAD 5-8, COMPUTE 9-22, DRAIN 23-26, done at 27, feed_idx 0..7 in cycles 9-16.
- ROWS=COLS=8, hor_stride=3, ver_stride=2 → each row of hor_ssr_bus_out = 8'b10110110 (bit7..0) and each column of ver_ssr_bus_out = 8'b10101010 from LOAD onward.
- Stride 0 and stride 12 on an 8×8 array → masks all-zero and 8'b11111110 respectively.
- k_len=0 → done one cycle after start, busy high for that one cycle, and no LOAD/COMPUTE activity.
- rst low during COMPUTE cycle 12, then released → all outputs 0 and a fresh start runs the full sequence; start pulsed during busy is ignored.
- With the macro defined, abort in LOAD → IDLE next cycle, ctl_stat_bit 0, SSR buses retained, no done pulse.
